// File: rtl/imem_stream_loader.sv
//------------------------------------------------------------------------------
// Module      : imem_stream_loader
// Description : Streams 16-bit instruction words over valid/ready into
//               instruction memory from address 0, holds the pipeline in
//               reset until the program is loaded and flushed, then releases
//               it with a done pulse and a running modulo-2^16 checksum.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_stream_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_in_valid,
  input  logic [15:0]       i_in_data,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_waddr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_checksum
);

  localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W:0]     r_rem;
  logic                r_flush;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [15:0]         r_wdata;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
  logic [15:0]         r_checksum;

  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_xfer;
  logic                w_last;
  logic                w_release_end;

  // Qualify start requests and detect transfers; completion is driven by the
  // remaining count so the address counter may wrap on a full-depth load.
  always_comb begin
    w_len_ok      = (i_len != '0) && (i_len <= C_DEPTH);
    w_start_ok    = (r_state == S_IDLE) && i_start && w_len_ok;
    w_start_bad   = (r_state == S_IDLE) && i_start && !w_len_ok;
    w_xfer        = (r_state == S_LOAD) && i_in_valid;
    w_last        = w_xfer && (r_rem == C_REM_ONE);
    w_release_end = (r_state == S_RELEASE) && r_flush;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok)    w_state_nxt = S_LOAD;
      S_LOAD:    if (w_last)        w_state_nxt = S_RELEASE;
      S_RELEASE: if (w_release_end) w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Control flags: two-cycle flush timer, pipeline reset, done/err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush   <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_flush <= (r_state == S_RELEASE) && !r_flush;
      r_done  <= w_release_end;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_cpu_rst <= 1'b1;
      end else if (w_release_end) begin
        r_cpu_rst <= 1'b0;
      end
    end
  end

  // Write port, word counters and checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_checksum <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_start_ok) begin
        r_cnt      <= '0;
        r_rem      <= i_len;
        r_checksum <= '0;
      end else if (w_xfer) begin
        r_waddr    <= r_cnt;
        r_wdata    <= i_in_data;
        r_checksum <= r_checksum + i_in_data;
        r_cnt      <= r_cnt + 1'b1;
        r_rem      <= r_rem - C_REM_ONE;
      end
    end
  end

  // Output mapping; ready and busy decode directly from state.
  always_comb begin
    o_in_ready   = (r_state == S_LOAD);
    o_busy       = (r_state != S_IDLE);
    o_imem_we    = r_we;
    o_imem_waddr = r_waddr;
    o_imem_wdata = r_wdata;
    o_cpu_rst    = r_cpu_rst;
    o_done       = r_done;
    o_err        = r_err;
    o_checksum   = r_checksum;
  end

endmodule

`default_nettype wire

// File: doc/imem_stream_loader.md
# imem_stream_loader

Writer-side companion to the 3-stage pipelined datapath. The datapath only reads instruction memory (PC → INST). This block is the other end of that interface. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive addresses from 0. It holds the pipeline in reset until the program is loaded and flushed, then releases it and reports completion and a checksum.

## Interface
- ADDR_W, 8, instruction-memory address width
- DEPTH, 256, maximum program length in words (must equal 2**ADDR_W)

- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- len  in  ADDR_W+1  number of words to load; legal range 1..DEPTH
- in_valid  in  1  source has a word on in_data
- in_data  in  16  instruction word
- in_ready  out  1  loader accepts a word this cycle
- imem_we  out  1  instruction-memory write enable (registered)
- imem_waddr  out  ADDR_W  write address (registered)
- imem_wdata  out  16  write data (registered)
- cpu_rst  out  1  drives the pipeline's rst; high while the program is not valid
- busy  out  1  high in LOAD and RELEASE
- done  out  1  one-cycle pulse when the pipeline is released
- err  out  1  one-cycle pulse when start carries an illegal len
- checksum  out  16  modulo-2^16 sum of all words accepted in the current or last load

## Operation
- **States:** IDLE, LOAD, RELEASE.
- **Reset values:**
  - state = IDLE, cpu_rst = 1.
  - in_ready, imem_we, busy, done, err = 0.
  - imem_waddr = 0, imem_wdata = 0, checksum = 0.
  - Internal word counter = 0, remaining = 0.
- **IDLE, start = 1 with 1 ≤ len ≤ DEPTH:**
  - Latch len into remaining.
  - Clear the counter and checksum.
  - Set cpu_rst = 1 and go to LOAD.
- **IDLE, start = 1 with len = 0 or len > DEPTH:** pulse err for one cycle; state, cpu_rst and checksum are unchanged.
- **LOAD:**
  - in_ready = 1 (combinational from state).
  - A transfer occurs on any edge where in_valid && in_ready.
  - On a transfer:
    - imem_waddr ← counter, imem_wdata ← in_data, imem_we ← 1.
    - checksum ← checksum + in_data, wrapping mod 2^16.
    - counter ← counter + 1 and remaining ← remaining − 1.
  - With no transfer, imem_we ← 0.
  - start is ignored in LOAD.
- **Last transfer in LOAD** (remaining = 1): go to RELEASE with flush counter = 0.
- **RELEASE:**
  - in_ready = 0 and cpu_rst stays 1.
  - Lasts exactly 2 cycles, for pipeline flush.
  - On leaving: state ← IDLE, cpu_rst ← 0, done ← 1 for one cycle.
- **IDLE after a load:**
  - cpu_rst stays 0 and checksum holds its value.
  - A new legal start re-asserts cpu_rst on the accepting edge.
- **busy** = (state ≠ IDLE).
- **len = DEPTH:** the final imem_waddr is DEPTH−1. The counter wrapping to 0 is harmless because completion is decided by remaining, not by the counter.
- **Reset mid-LOAD or mid-RELEASE:**
  - Immediate return to reset values; cpu_rst = 1.
  - No done pulse.
  - Any partially written memory is treated as invalid.

## Timing
- start accepted at edge S → in_ready = 1 in the cycle after S.
- Transfer at edge T → imem_we/imem_waddr/imem_wdata are valid for the cycle after T. checksum is updated at T.
- Back-to-back transfers sustain 1 word per cycle, with no bubbles inserted by the loader.
- Last transfer at edge L:
  - Edge L+1: last imem_we cycle ends, first RELEASE cycle ends.
  - Edge L+2: cpu_rst falls and done = 1.
  - Edge L+3: done returns to 0.
- Minimum start-to-done latency is len + 2 edges after S.
- err is asserted for the cycle following the start edge.
- Asynchronous rst takes effect without waiting for clk. Release is synchronous to the next edge.

## Test plan
- **Reset:** hold rst 50 ns → cpu_rst = 1; all other outputs 0; in_ready = 0.
- **Streaming load:** start with len = 3, in_valid held high, words 0x1234, 0x0001, 0xFFFF → writes (0,0x1234), (1,0x0001), (2,0xFFFF) on consecutive cycles; checksum = 0x1234 (wrapped); done one cycle exactly 2 cycles after the last transfer; cpu_rst falls with done.
- **Source stalls:** len = 2, in_valid low for 3 cycles between words 0xA000 and 0x0B00 → imem_we low during the gap; addresses 0 and 1; checksum = 0xAB00.
- **Illegal and ignored starts:** start with len = 0 → err pulse, state stays IDLE, cpu_rst unchanged. Start with len = 257 (ADDR_W = 8) → err pulse. Start pulsed during LOAD → ignored, load completes normally.
- **Reset mid-load:** len = 4, assert rst after 2 transfers → outputs return to reset values, no done pulse. A subsequent len = 1 load of 0x0042 writes address 0, and checksum = 0x0042.
- **Full depth:** len = 256 with data = index → last address 255, checksum = 0x7F80, done asserted once.
